aes_128_key_expand_wr: RTL and testbench

- AES-128 key-schedule producer; writer side of the round-key RAM write interface (en_wr / key_round_wr / wr_idle).
- Takes a 128-bit cipher key and generates the 11 round keys on the fly.
- Streams them as 22 contiguous 64-bit words into aes_128_keyram_2key, one word per clock, once the RAM reports wr_idle.

---
 rtl/aes_128_key_expand_wr.sv | 209 ++++++++++++++++++++
 tb/tb_aes_128_key_expand_wr.sv | 511 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_128_key_expand_wr.sv
// AES-128 key-schedule writer: expands a cipher key and streams 22 x 64-bit
// round-key words into the round-key RAM, one word per clock.
//
// Ports:
//   clk          rising-edge clock
//   kill         synchronous active-high reset, dominates all inputs
//   key_start    one-cycle request to expand key_in (only honoured in IDLE)
//   key_in       128-bit cipher key, byte 0 in bits [127:120]
//   wr_idle      RAM ready to accept a full burst
//   en_wr        registered write strobe
//   key_round_wr registered write data, zero when en_wr is low
//   busy         high from key_start acceptance until done
//   done         one-cycle pulse after the last word
//   key_last     (only with AES_KEY_LAST_OUT_EN) final round key, i.e. the
//                decryption start key; held until next load or kill
//
// Optional build macro: AES_KEY_LAST_OUT_EN adds the key_last output.

module aes_128_key_expand_wr (
    input  logic         clk,
    input  logic         kill,
    input  logic         key_start,
    input  logic [127:0] key_in,
    input  logic         wr_idle,
    output logic         en_wr,
    output logic [63:0]  key_round_wr,
    output logic         busy,
    output logic         done
`ifdef AES_KEY_LAST_OUT_EN
    ,
    output logic [127:0] key_last
`endif
);

    localparam int NWORDS = 22;
    localparam logic [3:0] LAST_ROUND = 4'(NWORDS / 2 - 1);

    // Row-major S-box: entry x lives at bits [8*(255-x) +: 8].
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        // ~x == 255 - x, so {~x, 3'b0} is the bit offset of entry x.
        return SBOX_TBL[{~x, 3'b000} +: 8];
    endfunction

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_WR_HI,
        S_WR_LO,
        S_FIN
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic [127:0] r_key;
    logic [127:0] w_key_nxt;
    logic [7:0]   r_rcon;
    logic [7:0]   w_rcon_nxt;
    logic [3:0]   r_round;
    logic [3:0]   w_round_nxt;
    logic         r_en_wr;
    logic         w_en_wr_nxt;
    logic [63:0]  r_wdata;
    logic [63:0]  w_wdata_nxt;
    logic         r_busy;
    logic         w_busy_nxt;
    logic         r_done;
    logic         w_done_nxt;

    // Next round key from the current one.
    logic [31:0]  w_w3;
    logic [31:0]  w_t;
    logic [31:0]  w_n0;
    logic [31:0]  w_n1;
    logic [31:0]  w_n2;
    logic [31:0]  w_n3;
    logic [127:0] w_key_exp;
    logic [7:0]   w_rcon_x;

    assign w_w3 = r_key[31:0];

    // SubWord(RotWord(w3)): rotation folded into the byte order.
    assign w_t = {sbox(w_w3[23:16]), sbox(w_w3[15:8]),
                  sbox(w_w3[7:0]),   sbox(w_w3[31:24])}
               ^ {r_rcon, 24'h0};

    assign w_n0 = r_key[127:96] ^ w_t;
    assign w_n1 = r_key[95:64]  ^ w_n0;
    assign w_n2 = r_key[63:32]  ^ w_n1;
    assign w_n3 = w_w3          ^ w_n2;
    assign w_key_exp = {w_n0, w_n1, w_n2, w_n3};

    assign w_rcon_x = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);

    always_ff @(posedge clk) begin
        if (kill) begin
            r_state <= S_IDLE;
            r_key   <= '0;
            r_rcon  <= '0;
            r_round <= '0;
            r_en_wr <= 1'b0;
            r_wdata <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_key   <= w_key_nxt;
            r_rcon  <= w_rcon_nxt;
            r_round <= w_round_nxt;
            r_en_wr <= w_en_wr_nxt;
            r_wdata <= w_wdata_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_key_nxt   = r_key;
        w_rcon_nxt  = r_rcon;
        w_round_nxt = r_round;
        w_en_wr_nxt = 1'b0;
        w_wdata_nxt = '0;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (key_start) begin
                    w_key_nxt   = key_in;
                    w_rcon_nxt  = 8'h01;
                    w_round_nxt = '0;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                // Once ready, the whole burst goes out without rechecking.
                if (wr_idle) begin
                    w_state_nxt = S_WR_HI;
                end
            end
            S_WR_HI: begin
                w_en_wr_nxt = 1'b1;
                w_wdata_nxt = r_key[127:64];
                w_state_nxt = S_WR_LO;
            end
            S_WR_LO: begin
                w_en_wr_nxt = 1'b1;
                w_wdata_nxt = r_key[63:0];
                if (r_round == LAST_ROUND) begin
                    w_state_nxt = S_FIN;
                end else begin
                    w_key_nxt   = w_key_exp;
                    w_rcon_nxt  = w_rcon_x;
                    w_round_nxt = r_round + 4'd1;
                    w_state_nxt = S_WR_HI;
                end
            end
            S_FIN: begin
                w_done_nxt  = 1'b1;
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign en_wr        = r_en_wr;
    assign key_round_wr = r_wdata;
    assign busy         = r_busy;
    assign done         = r_done;

`ifdef AES_KEY_LAST_OUT_EN
    logic [127:0] r_key_last;

    always_ff @(posedge clk) begin
        if (kill) begin
            r_key_last <= '0;
        end else if (r_state == S_IDLE && key_start) begin
            r_key_last <= '0;
        end else if (r_state == S_WR_LO && r_round == LAST_ROUND) begin
            r_key_last <= r_key;
        end
    end

    assign key_last = r_key_last;
`endif

endmodule

// File: tb/tb_aes_128_key_expand_wr.sv
// Self-checking bench for aes_128_key_expand_wr: scoreboard of expected
// round-key words built from an independent GF(2^8) S-box model.

module tb_aes_128_key_expand_wr;

    logic         clk = 1'b0;
    logic         kill;
    logic         key_start;
    logic [127:0] key_in;
    logic         wr_idle;
    logic         en_wr;
    logic [63:0]  key_round_wr;
    logic         busy;
    logic         done;
`ifdef AES_KEY_LAST_OUT_EN
    logic [127:0] key_last;
`endif

    aes_128_key_expand_wr dut (
        .clk          (clk),
        .kill         (kill),
        .key_start    (key_start),
        .key_in       (key_in),
        .wr_idle      (wr_idle),
        .en_wr        (en_wr),
        .key_round_wr (key_round_wr),
        .busy         (busy),
        .done         (done)
`ifdef AES_KEY_LAST_OUT_EN
        ,
        .key_last     (key_last)
`endif
    );

    always #5 clk = ~clk;

    localparam logic [127:0] K_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q[$];
    logic [7:0]  sb[256];
    logic [63:0] got[32];
    int          n;
    int          first_c;
    int          last_c;
    int          done_c;
    int          gaps;
    int          zviol;
    int          bviol;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    // S-box from multiplicative inverse plus affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] xv;
        logic [7:0] yv;
        for (int x = 0; x < 256; x++) begin
            xv = x[7:0];
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                yv = y[7:0];
                if (gmul(xv, yv) == 8'h01) inv = yv;
            end
            sb[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                  ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] m_expand(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w3;
        logic [31:0] t;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] d;
        w3 = k[31:0];
        t = {sb[w3[23:16]], sb[w3[15:8]], sb[w3[7:0]], sb[w3[31:24]]} ^ {rc, 24'h0};
        a = k[127:96] ^ t;
        b = k[95:64] ^ a;
        c = k[63:32] ^ b;
        d = w3 ^ c;
        return {a, b, c, d};
    endfunction

    task automatic push_burst(input logic [127:0] k);
        logic [127:0] kk;
        logic [7:0]   rc;
        kk = k;
        rc = 8'h01;
        for (int r = 0; r <= 10; r++) begin
            exp_q.push_back(kk[127:64]);
            exp_q.push_back(kk[63:0]);
            if (r < 10) begin
                kk = m_expand(kk, rc);
                rc = rc[7] ? ({rc[6:0], 1'b0} ^ 8'h1b) : {rc[6:0], 1'b0};
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_key(input logic [127:0] k);
        key_in = k;
        key_start = 1'b1;
        push_burst(k);
        step();
        key_start = 1'b0;
    endtask

    // Records what the DUT emits; cycle c counts edges since acceptance.
    task automatic collect(input int budget, input bit tgl,
                           input int ks_at, input logic [127:0] ks_key);
        n = 0; first_c = -1; last_c = -1; done_c = -1;
        gaps = 0; zviol = 0; bviol = 0;
        for (int c = 1; c <= budget; c++) begin
            step();
            if (tgl) wr_idle = c[0];
            if (ks_at > 0) begin
                key_start = (c == ks_at);
                if (c == ks_at) key_in = ks_key;
            end
            if (en_wr) begin
                if (n == 0) first_c = c;
                else if (c != last_c + 1) gaps++;
                if (n < 32) got[n] = key_round_wr;
                n++;
                last_c = c;
                if (!busy) bviol++;
            end else if (key_round_wr != 64'h0) begin
                zviol++;
            end
            if (done) begin
                done_c = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        kill = 1'b1; key_start = 1'b1; key_in = K_FIPS; wr_idle = 1'b1;
        step();
        step();
        checks++;
        if ({en_wr, busy, done} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctl: en/busy/done=%b want 000", {en_wr, busy, done});
        end
        checks++;
        if (key_round_wr !== 64'h0) begin
            errors++;
            $display("FAIL reset_data: got %h want 0", key_round_wr);
        end
        kill = 1'b0; key_start = 1'b0;
        step();
        step();
        checks++;
        if ({en_wr, busy} !== 2'b00) begin
            errors++;
            $display("FAIL reset_idle: en/busy=%b want 00", {en_wr, busy});
        end
`ifdef AES_KEY_LAST_OUT_EN
        checks++;
        if (key_last !== 128'h0) begin
            errors++;
            $display("FAIL reset_klast: got %h want 0", key_last);
        end
`endif
    endtask

    task automatic test_fips();
        logic [63:0] e;
        start_key(K_FIPS);
        collect(40, 1'b0, 0, 128'h0);
        for (int i = 0; i < n && i < 32; i++) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL fips_sb: word %0d got %h, none expected", i, got[i]);
            end else begin
                e = exp_q.pop_front();
                if (got[i] !== e) begin
                    errors++;
                    $display("FAIL fips_sb: word %0d got %h want %h", i, got[i], e);
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL fips_left: %0d words missing", exp_q.size());
            exp_q.delete();
        end
        checks++;
        if ({got[0], got[1]} !== K_FIPS) begin
            errors++;
            $display("FAIL fips_w01: got %h%h want %h", got[0], got[1], K_FIPS);
        end
        checks++;
        if ({got[2], got[3]} !== 128'ha0fafe1788542cb123a339392a6c7605) begin
            errors++;
            $display("FAIL fips_w23: got %h%h want a0fafe17...2a6c7605", got[2], got[3]);
        end
        checks++;
        if ({got[20], got[21]} !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
            errors++;
            $display("FAIL fips_w2021: got %h%h want d014f9a8...b6630ca6", got[20], got[21]);
        end
        checks++;
        if (n != 22 || gaps != 0) begin
            errors++;
            $display("FAIL fips_shape: words %0d gaps %0d want 22/0", n, gaps);
        end
        checks++;
        if (first_c != 2 || last_c != 23 || done_c != 24) begin
            errors++;
            $display("FAIL fips_lat: first %0d last %0d done %0d want 2/23/24",
                     first_c, last_c, done_c);
        end
        checks++;
        if (zviol != 0 || bviol != 0) begin
            errors++;
            $display("FAIL fips_idle: nonzero data %0d, busy low %0d want 0/0", zviol, bviol);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL fips_busy_end: got %b want 0", busy);
        end
        step();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL fips_done_pulse: got %b want 0", done);
        end
    endtask

    task automatic test_zero_key();
        logic [63:0] e;
        start_key(128'h0);
        collect(40, 1'b0, 0, 128'h0);
        for (int i = 0; i < n && i < 32; i++) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL zero_sb: word %0d got %h, none expected", i, got[i]);
            end else begin
                e = exp_q.pop_front();
                if (got[i] !== e) begin
                    errors++;
                    $display("FAIL zero_sb: word %0d got %h want %h", i, got[i], e);
                end
            end
        end
        exp_q.delete();
        checks++;
        if ({got[2], got[3]} !== 128'h62636363626363636263636362636363) begin
            errors++;
            $display("FAIL zero_w23: got %h%h want 62636363...", got[2], got[3]);
        end
        checks++;
        if ({got[20], got[21]} !== 128'hb4ef5bcb3e92e21123e951cf6f8f188e) begin
            errors++;
            $display("FAIL zero_w2021: got %h%h want b4ef5bcb...6f8f188e", got[20], got[21]);
        end
        checks++;
        if (n != 22 || done_c != 24) begin
            errors++;
            $display("FAIL zero_shape: words %0d done %0d want 22/24", n, done_c);
        end
`ifdef AES_KEY_LAST_OUT_EN
        checks++;
        if (key_last !== 128'hb4ef5bcb3e92e21123e951cf6f8f188e) begin
            errors++;
            $display("FAIL zero_klast: got %h want b4ef5bcb...6f8f188e", key_last);
        end
`endif
        step();
    endtask

    task automatic test_wait_idle();
        logic [63:0]  e;
        logic [127:0] k;
        int           bad;
        k = {$urandom, $urandom, $urandom, $urandom};
        wr_idle = 1'b0;
        start_key(k);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (en_wr !== 1'b0 || busy !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL wait_hold: %0d bad cycles want 0", bad);
        end
        wr_idle = 1'b1;
        collect(40, 1'b1, 0, 128'h0);
        wr_idle = 1'b1;
        for (int i = 0; i < n && i < 32; i++) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL wait_sb: word %0d got %h, none expected", i, got[i]);
            end else begin
                e = exp_q.pop_front();
                if (got[i] !== e) begin
                    errors++;
                    $display("FAIL wait_sb: word %0d got %h want %h", i, got[i], e);
                end
            end
        end
        exp_q.delete();
        checks++;
        if (first_c != 2 || n != 22 || gaps != 0) begin
            errors++;
            $display("FAIL wait_shape: first %0d words %0d gaps %0d want 2/22/0",
                     first_c, n, gaps);
        end
        step();
    endtask

    task automatic test_ignore_start();
        logic [63:0] e;
        start_key(K_FIPS);
        collect(40, 1'b0, 6, 128'h00112233445566778899aabbccddeeff);
        key_start = 1'b0;
        for (int i = 0; i < n && i < 32; i++) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL ign_sb: word %0d got %h, none expected", i, got[i]);
            end else begin
                e = exp_q.pop_front();
                if (got[i] !== e) begin
                    errors++;
                    $display("FAIL ign_sb: word %0d got %h want %h", i, got[i], e);
                end
            end
        end
        exp_q.delete();
        checks++;
        if (n != 22 || done_c != 24) begin
            errors++;
            $display("FAIL ign_shape: words %0d done %0d want 22/24", n, done_c);
        end
        step();
        step();
        checks++;
        if ({en_wr, busy} !== 2'b00) begin
            errors++;
            $display("FAIL ign_after: en/busy=%b want 00", {en_wr, busy});
        end
    endtask

    task automatic test_kill();
        logic [63:0]  e;
        logic [127:0] k;
        int           seen;
        k = {$urandom, $urandom, $urandom, $urandom};
        start_key(K_FIPS);
        seen = 0;
        for (int c = 0; c < 40 && seen < 8; c++) begin
            step();
            if (en_wr) begin
                got[seen] = key_round_wr;
                seen++;
            end
        end
        kill = 1'b1;
        step();
        kill = 1'b0;
        checks++;
        if ({en_wr, busy, done} !== 3'b000 || key_round_wr !== 64'h0) begin
            errors++;
            $display("FAIL kill_out: en/busy/done=%b data %h want 000/0",
                     {en_wr, busy, done}, key_round_wr);
        end
`ifdef AES_KEY_LAST_OUT_EN
        checks++;
        if (key_last !== 128'h0) begin
            errors++;
            $display("FAIL kill_klast: got %h want 0", key_last);
        end
`endif
        for (int i = 0; i < seen; i++) begin
            checks++;
            e = exp_q.pop_front();
            if (got[i] !== e) begin
                errors++;
                $display("FAIL kill_part: word %0d got %h want %h", i, got[i], e);
            end
        end
        exp_q.delete();
        start_key(k);
        collect(40, 1'b0, 0, 128'h0);
        for (int i = 0; i < n && i < 32; i++) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL kill_sb: word %0d got %h, none expected", i, got[i]);
            end else begin
                e = exp_q.pop_front();
                if (got[i] !== e) begin
                    errors++;
                    $display("FAIL kill_sb: word %0d got %h want %h", i, got[i], e);
                end
            end
        end
        exp_q.delete();
        checks++;
        if (first_c != 2 || n != 22 || done_c != 24) begin
            errors++;
            $display("FAIL kill_reload: first %0d words %0d done %0d want 2/22/24",
                     first_c, n, done_c);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [63:0]  e;
        logic [127:0] k1;
        logic [127:0] k2;
        int           last1;
        int           done1;
        int           gap_cyc;
        int           bad;
        k1 = {$urandom, $urandom, $urandom, $urandom};
        k2 = {$urandom, $urandom, $urandom, $urandom};
        key_in = k1;
        key_start = 1'b1;
        push_burst(k1);
        step();
        key_in = k2;
        collect(40, 1'b0, 0, 128'h0);
        last1 = last_c;
        done1 = done_c;
        bad = (n != 22) ? 1 : 0;
        push_burst(k2);
        step();
        key_start = 1'b0;
        if (en_wr !== 1'b0) bad++;
        for (int i = 0; i < 22; i++) begin
            checks++;
            e = exp_q.pop_front();
            if (got[i] !== e) begin
                errors++;
                $display("FAIL b2b_sb1: word %0d got %h want %h", i, got[i], e);
            end
        end
        collect(40, 1'b0, 0, 128'h0);
        for (int i = 0; i < n && i < 32; i++) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL b2b_sb2: word %0d got %h, none expected", i, got[i]);
            end else begin
                e = exp_q.pop_front();
                if (got[i] !== e) begin
                    errors++;
                    $display("FAIL b2b_sb2: word %0d got %h want %h", i, got[i], e);
                end
            end
        end
        exp_q.delete();
        gap_cyc = (done1 - last1) + 1 + (first_c - 1);
        checks++;
        if (bad != 0 || n != 22 || gap_cyc != 3) begin
            errors++;
            $display("FAIL b2b_shape: bad %0d words %0d idle gap %0d want 0/22/3",
                     bad, n, gap_cyc);
        end
        step();
    endtask

    initial begin
        kill = 1'b1;
        key_start = 1'b0;
        key_in = '0;
        wr_idle = 1'b1;
        build_sbox();
        test_reset();
        test_fips();
        test_zero_key();
        test_wait_idle();
        test_ignore_start();
        test_kill();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
